// File: rtl/alarm_pkg.sv
// Shared state encoding, time limits and LED patterns for the alarm scheduler.
package alarm_pkg;

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        RINGING  = 2'd2,
        SNOOZE   = 2'd3
    } alarm_state_t;

    localparam logic [4:0] HH_MAX = 5'd23;
    localparam logic [5:0] MM_MAX = 6'd59;

    localparam logic [15:0] LED_OFF     = 16'h0000;
    localparam logic [15:0] LED_ARMED   = 16'h8000;
    localparam logic [15:0] LED_RING_ON = 16'hFFFF;

    // Remaining seconds to whole minutes, rounded up (0 s -> 0, 1..60 s -> 1, ...).
    function automatic logic [3:0] minutes_left(input logic [15:0] secs);
        logic [15:0] mins;
        mins = (secs + 16'd59) / 16'd60;
        return mins[3:0];
    endfunction

endpackage

// File: rtl/alarm_countdown.sv
// Loadable down counter advanced by sec_tick; done flags the tick that takes it from 1 to 0.
module alarm_countdown #(
    parameter int unsigned LOAD_VAL = 60,
    parameter int unsigned W        = $clog2(LOAD_VAL + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         tick,
    output logic [W-1:0] cnt_next,
    output logic         done
);

    logic [W-1:0] cnt_q;

    // Load wins over tick; the count holds at zero rather than wrapping.
    always_comb begin
        cnt_next = cnt_q;
        if (load) begin
            cnt_next = W'(LOAD_VAL);
        end else if (tick && (cnt_q != '0)) begin
            cnt_next = cnt_q - 1'b1;
        end
    end

    // Independent of load so the FSM can consume it without a combinational loop.
    assign done = tick && (cnt_q == W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_next;
        end
    end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm scheduler: stores HH:MM, triggers at ss==0, sequences arm/ring/snooze/stop, drives LEDs.
// Snooze support is built only when ALARM_SNOOZE_EN is defined.
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int unsigned RING_SEC   = 60,
    parameter int unsigned SNOOZE_MIN = 5
) (
    input  logic        CLK100MHZ,
    input  logic        BTNC,
    input  logic        sec_tick,
    input  logic [4:0]  cur_hh,
    input  logic [5:0]  cur_mm,
    input  logic [5:0]  cur_ss,
    input  logic        arm,
    input  logic        stop,
    input  logic        snooze,
    input  logic        set_valid,
    input  logic [4:0]  set_hh,
    input  logic [5:0]  set_mm,
    output logic        set_ready,
    output logic        set_err,
    output logic        ringing,
    output logic [1:0]  state,
    output logic [15:0] LED
);

    localparam int unsigned RING_W = $clog2(RING_SEC + 1);

    alarm_state_t      state_q, state_d;
    logic [4:0]        alm_hh_q;
    logic [5:0]        alm_mm_q;
    logic              set_err_q;
    logic              ringing_q;
    logic [15:0]       led_q, led_d;
    logic              set_accept, set_bad, trigger;
    logic              ring_load, ring_tick, ring_done;
    logic [RING_W-1:0] ring_next;

    assign set_ready  = (state_q == DISARMED) || (state_q == ARMED);
    assign set_accept = set_valid && set_ready;
    assign set_bad    = (set_hh > HH_MAX) || (set_mm > MM_MAX);

    // Uses the stored time, so a write accepted this cycle does not affect this compare.
    assign trigger = sec_tick && (cur_hh == alm_hh_q) && (cur_mm == alm_mm_q)
                     && (cur_ss == 6'd0);

    assign ring_load = (state_d == RINGING) && (state_q != RINGING);
    assign ring_tick = sec_tick && (state_q == RINGING);

    alarm_countdown #(
        .LOAD_VAL (RING_SEC),
        .W        (RING_W)
    ) u_ring (
        .clk      (CLK100MHZ),
        .rst      (BTNC),
        .load     (ring_load),
        .tick     (ring_tick),
        .cnt_next (ring_next),
        .done     (ring_done)
    );

`ifdef ALARM_SNOOZE_EN
    localparam int unsigned SNOOZE_SEC = SNOOZE_MIN * 60;
    localparam int unsigned SNOOZE_W   = $clog2(SNOOZE_SEC + 1);

    logic                snooze_load, snooze_tick, snooze_done;
    logic [SNOOZE_W-1:0] snooze_next;

    assign snooze_load = (state_d == SNOOZE) && (state_q != SNOOZE);
    assign snooze_tick = sec_tick && (state_q == SNOOZE);

    alarm_countdown #(
        .LOAD_VAL (SNOOZE_SEC),
        .W        (SNOOZE_W)
    ) u_snooze (
        .clk      (CLK100MHZ),
        .rst      (BTNC),
        .load     (snooze_load),
        .tick     (snooze_tick),
        .cnt_next (snooze_next),
        .done     (snooze_done)
    );
`else
    logic snooze_unused;
    assign snooze_unused = snooze;
`endif

    always_comb begin
        state_d = state_q;
        if (!arm) begin
            state_d = DISARMED;
        end else begin
            case (state_q)
                DISARMED: state_d = ARMED;
                ARMED: begin
                    if (trigger) state_d = RINGING;
                end
                RINGING: begin
                    if (stop) begin
                        state_d = ARMED;
`ifdef ALARM_SNOOZE_EN
                    end else if (snooze) begin
                        state_d = SNOOZE;
`endif
                    end else if (ring_done) begin
                        state_d = ARMED;
                    end
                end
`ifdef ALARM_SNOOZE_EN
                SNOOZE: begin
                    if (stop) begin
                        state_d = ARMED;
                    end else if (snooze_done) begin
                        state_d = RINGING;
                    end
                end
`endif
                default: state_d = DISARMED;
            endcase
        end
    end

    // Ring pattern is on whenever an even number of ticks has elapsed since entry.
    always_comb begin
        led_d = LED_OFF;
        case (state_d)
            ARMED:   led_d = LED_ARMED;
            RINGING: led_d = ((ring_next & RING_W'(1)) == RING_W'(RING_SEC % 2)) ?
                             LED_RING_ON : LED_OFF;
`ifdef ALARM_SNOOZE_EN
            SNOOZE:  led_d = {1'b1, 11'b0, minutes_left(16'(snooze_next))};
`endif
            default: led_d = LED_OFF;
        endcase
    end

    always_ff @(posedge CLK100MHZ) begin
        if (BTNC) begin
            state_q   <= DISARMED;
            alm_hh_q  <= 5'd0;
            alm_mm_q  <= 6'd0;
            set_err_q <= 1'b0;
            ringing_q <= 1'b0;
            led_q     <= LED_OFF;
        end else begin
            state_q   <= state_d;
            set_err_q <= set_accept && set_bad;
            ringing_q <= (state_d == RINGING);
            led_q     <= led_d;
            if (set_accept && !set_bad) begin
                alm_hh_q <= set_hh;
                alm_mm_q <= set_mm;
            end
        end
    end

    assign state   = state_q;
    assign set_err = set_err_q;
    assign ringing = ringing_q;
    assign LED     = led_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Scoreboard bench for alarm_ctrl with RING_SEC=4, SNOOZE_MIN=1.
module tb_alarm_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        btnc, sec_tick, arm, stop, snooze, set_valid;
    logic [4:0]  cur_hh, set_hh;
    logic [5:0]  cur_mm, cur_ss, set_mm;
    logic        set_ready, set_err, ringing;
    logic [1:0]  state;
    logic [15:0] led;

    alarm_ctrl #(
        .RING_SEC   (4),
        .SNOOZE_MIN (1)
    ) dut (
        .CLK100MHZ (clk),
        .BTNC      (btnc),
        .sec_tick  (sec_tick),
        .cur_hh    (cur_hh),
        .cur_mm    (cur_mm),
        .cur_ss    (cur_ss),
        .arm       (arm),
        .stop      (stop),
        .snooze    (snooze),
        .set_valid (set_valid),
        .set_hh    (set_hh),
        .set_mm    (set_mm),
        .set_ready (set_ready),
        .set_err   (set_err),
        .ringing   (ringing),
        .state     (state),
        .LED       (led)
    );

    typedef struct {
        string       name;
        int          cyc;
        logic [1:0]  st;
        logic        rg;
        logic [15:0] ld;
        logic        er;
        logic        rd;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: outputs are presented every cycle; compare those the stimulus scheduled.
    always @(negedge clk) begin : monitor
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            n_cmp++;
            if (e.cyc != cyc) begin
                n_bad++;
                $display("FAIL %s: compared at cycle %0d, required cycle %0d", e.name, cyc, e.cyc);
            end else if (state !== e.st || ringing !== e.rg || led !== e.ld ||
                         set_err !== e.er || set_ready !== e.rd) begin
                n_bad++;
                $display("FAIL %s: got state=%0d ringing=%b LED=%h set_err=%b set_ready=%b, required state=%0d ringing=%b LED=%h set_err=%b set_ready=%b",
                         e.name, state, ringing, led, set_err, set_ready,
                         e.st, e.rg, e.ld, e.er, e.rd);
            end
        end
    end

    // Expected outputs after the next active edge.
    task automatic expect_next(input string nm, input logic [1:0] st, input logic rg,
                               input logic [15:0] ld, input logic er, input logic rd);
        exp_t e;
        e.name = nm;
        e.cyc  = cyc + 1;
        e.st   = st;
        e.rg   = rg;
        e.ld   = ld;
        e.er   = er;
        e.rd   = rd;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        sec_tick  = 1'b0;
        stop      = 1'b0;
        snooze    = 1'b0;
        set_valid = 1'b0;
    endtask

    task automatic tick(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        cur_hh   = h;
        cur_mm   = m;
        cur_ss   = s;
        sec_tick = 1'b1;
    endtask

    task automatic write(input logic [4:0] h, input logic [5:0] m);
        set_hh    = h;
        set_mm    = m;
        set_valid = 1'b1;
    endtask

    initial begin
        btnc = 1'b1; arm = 1'b0; sec_tick = 1'b0; stop = 1'b0; snooze = 1'b0;
        set_valid = 1'b0; set_hh = '0; set_mm = '0; cur_hh = '0; cur_mm = '0; cur_ss = '0;

        expect_next("reset", 2'd0, 1'b0, 16'h0000, 1'b0, 1'b1); step();
        btnc = 1'b0; arm = 1'b1;
        expect_next("arm", 2'd1, 1'b0, 16'h8000, 1'b0, 1'b1); step();
        write(5'd7, 6'd30);
        expect_next("set_0730", 2'd1, 1'b0, 16'h8000, 1'b0, 1'b1); step();

        tick(5'd7, 6'd30, 6'd0);
        expect_next("trigger", 2'd2, 1'b1, 16'hFFFF, 1'b0, 1'b0); step();
        tick(5'd7, 6'd30, 6'd1);
        expect_next("ring_tick1", 2'd2, 1'b1, 16'h0000, 1'b0, 1'b0); step();
        expect_next("ring_hold", 2'd2, 1'b1, 16'h0000, 1'b0, 1'b0); step();
        tick(5'd7, 6'd30, 6'd2);
        expect_next("ring_tick2", 2'd2, 1'b1, 16'hFFFF, 1'b0, 1'b0); step();
        tick(5'd7, 6'd30, 6'd3);
        expect_next("ring_tick3", 2'd2, 1'b1, 16'h0000, 1'b0, 1'b0); step();
        tick(5'd7, 6'd30, 6'd4);
        expect_next("ring_timeout", 2'd1, 1'b0, 16'h8000, 1'b0, 1'b1); step();
        tick(5'd7, 6'd30, 6'd5);
        expect_next("no_retrigger", 2'd1, 1'b0, 16'h8000, 1'b0, 1'b1); step();

        write(5'd24, 6'd10);
        expect_next("bad_hh_err", 2'd1, 1'b0, 16'h8000, 1'b1, 1'b1); step();
        expect_next("err_one_cycle", 2'd1, 1'b0, 16'h8000, 1'b0, 1'b1); step();
        write(5'd12, 6'd60);
        expect_next("bad_mm_err", 2'd1, 1'b0, 16'h8000, 1'b1, 1'b1); step();
        tick(5'd7, 6'd30, 6'd0);
        expect_next("alarm_kept_after_bad", 2'd2, 1'b1, 16'hFFFF, 1'b0, 1'b0); step();
        write(5'd5, 6'd0);
        expect_next("set_in_ring", 2'd2, 1'b1, 16'hFFFF, 1'b0, 1'b0); step();

`ifdef ALARM_SNOOZE_EN
        snooze = 1'b1;
        expect_next("snooze", 2'd3, 1'b0, 16'h8001, 1'b0, 1'b0); step();
        snooze = 1'b1;
        expect_next("snooze_again_ignored", 2'd3, 1'b0, 16'h8001, 1'b0, 1'b0); step();
        for (int i = 1; i <= 60; i++) begin
            tick(5'd7, 6'd31, 6'd1);
            if (i == 59) expect_next("snooze_59", 2'd3, 1'b0, 16'h8001, 1'b0, 1'b0);
            if (i == 60) expect_next("snooze_rering", 2'd2, 1'b1, 16'hFFFF, 1'b0, 1'b0);
            step();
        end
`else
        snooze = 1'b1;
        expect_next("snooze_ignored", 2'd2, 1'b1, 16'hFFFF, 1'b0, 1'b0); step();
`endif
        snooze = 1'b1; stop = 1'b1;
        expect_next("stop_beats_snooze", 2'd1, 1'b0, 16'h8000, 1'b0, 1'b1); step();
        tick(5'd5, 6'd0, 6'd0);
        expect_next("ring_write_dropped", 2'd1, 1'b0, 16'h8000, 1'b0, 1'b1); step();

        tick(5'd7, 6'd30, 6'd0);
        expect_next("trigger_again", 2'd2, 1'b1, 16'hFFFF, 1'b0, 1'b0); step();
        arm = 1'b0;
        expect_next("disarm_in_ring", 2'd0, 1'b0, 16'h0000, 1'b0, 1'b1); step();
        tick(5'd7, 6'd30, 6'd0);
        expect_next("disarmed_no_trigger", 2'd0, 1'b0, 16'h0000, 1'b0, 1'b1); step();
        arm = 1'b1;
        expect_next("rearm", 2'd1, 1'b0, 16'h8000, 1'b0, 1'b1); step();
        tick(5'd7, 6'd30, 6'd0);
        expect_next("trigger_pre_reset", 2'd2, 1'b1, 16'hFFFF, 1'b0, 1'b0); step();
`ifdef ALARM_SNOOZE_EN
        snooze = 1'b1;
        expect_next("snooze_pre_reset", 2'd3, 1'b0, 16'h8001, 1'b0, 1'b0); step();
`endif
        btnc = 1'b1;
        expect_next("btnc_reset", 2'd0, 1'b0, 16'h0000, 1'b0, 1'b1); step();
        btnc = 1'b0;
        expect_next("after_reset_arm", 2'd1, 1'b0, 16'h8000, 1'b0, 1'b1); step();
        tick(5'd7, 6'd30, 6'd0);
        expect_next("alarm_time_lost", 2'd1, 1'b0, 16'h8000, 1'b0, 1'b1); step();

        // Trigger compares the old 00:00 while the same-cycle write stores 09:15.
        tick(5'd0, 6'd0, 6'd0); write(5'd9, 6'd15);
        expect_next("trigger_with_write", 2'd2, 1'b1, 16'hFFFF, 1'b0, 1'b0); step();
        stop = 1'b1;
        expect_next("stop", 2'd1, 1'b0, 16'h8000, 1'b0, 1'b1); step();
        tick(5'd9, 6'd15, 6'd0);
        expect_next("new_time_stored", 2'd2, 1'b1, 16'hFFFF, 1'b0, 1'b0); step();

        for (int k = 0; k < 10 && sb.size() > 0; k++) step();
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
